// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared FSM states, LM/SM mode encodings and default widths for data_memory_burst
package data_memory_pkg;
   typedef enum logic [1:0] {INIT, IDLE, BURST, DONE} state_t;
   localparam logic MODE_LM = 1'b0;
   localparam logic MODE_SM = 1'b1;
   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 8;
   localparam int NREG_DEF = 8;
endpackage

// File: rtl/lmsm_mask_scan.sv
// lmsm_mask_scan: lowest-set-bit encoder; mask in, idx/valid of lowest set bit and rest (mask with it cleared) out
module lmsm_mask_scan import data_memory_pkg::*; #(
   parameter int NREG = NREG_DEF
) (
   input  logic [NREG-1:0]         mask,
   output logic [$clog2(NREG)-1:0] idx,
   output logic                    valid,
   output logic [NREG-1:0]         rest
);
   localparam int IW = $clog2(NREG);
   always_comb begin
      idx = '0;
      for (int i = NREG - 1; i >= 0; i--) if (mask[i]) idx = IW'(i);
   end
   assign valid = |mask;
   assign rest = mask & (mask - 1'b1);
endmodule

// File: rtl/data_memory_burst.sv
// data_memory_burst: word memory with post-reset clear and LM/SM burst engine; ports: clk/reset, single rd/wr port (+wr_drop), burst start/mode/base_addr/mask, regfile reg_idx/reg_rdata/reg_we/reg_wdata, busy/done
module data_memory_burst import data_memory_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NREG = NREG_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_W-1:0]       rd_addr,
   output logic [DATA_W-1:0]       rd_data,
   input  logic                    wr_en,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [DATA_W-1:0]       wr_data,
   output logic                    wr_drop,
   input  logic                    start,
   input  logic                    mode,
   input  logic [ADDR_W-1:0]       base_addr,
   input  logic [NREG-1:0]         mask,
   output logic [$clog2(NREG)-1:0] reg_idx,
   input  logic [DATA_W-1:0]       reg_rdata,
   output logic                    reg_we,
   output logic [DATA_W-1:0]       reg_wdata,
   output logic                    busy,
   output logic                    done
);
   localparam int DEPTH = 2 ** ADDR_W;
   state_t state, state_d;
   logic [ADDR_W-1:0] cnt, base_q, k, addr, mem_wa;
   logic [NREG-1:0] mask_q, rest;
   logic mode_q, vld, mem_we;
   logic [$clog2(NREG)-1:0] idx;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] mem_wd;
   lmsm_mask_scan #(.NREG(NREG)) u_scan (.mask(mask_q), .idx(idx), .valid(vld), .rest(rest));
   always_comb begin
      state_d = state;
      unique case (state)
         INIT:    if (&cnt) state_d = IDLE;
         IDLE:    if (start) state_d = |mask ? BURST : DONE;
         BURST:   if (~|rest) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= INIT;
         cnt <= '0;
         base_q <= '0;
         mask_q <= '0;
         mode_q <= MODE_LM;
         k <= '0;
      end else begin
         state <= state_d;
         if (state == INIT) cnt <= cnt + 1'b1;
         if (state == IDLE && start) begin
            mode_q <= mode;
            base_q <= base_addr;
            mask_q <= mask;
            k <= '0;
         end
         if (state == BURST) begin
            mask_q <= rest;
            k <= k + 1'b1;
         end
      end
   end
   assign addr = base_q + k;
   assign busy = state == INIT || state == BURST;
   assign done = state == DONE;
   assign reg_we = state == BURST && vld && mode_q == MODE_LM;
   assign reg_idx = state == BURST ? idx : '0;
   assign reg_wdata = reg_we ? mem[addr] : '0;
   assign wr_drop = reset && wr_en && busy;
   assign mem_we = reset && (state == INIT || (state == BURST && vld && mode_q == MODE_SM) || (wr_en && !busy));
   assign mem_wa = state == INIT ? cnt : state == BURST ? addr : wr_addr;
   assign mem_wd = state == INIT ? '0 : state == BURST ? reg_rdata : wr_data;
   always_ff @(posedge clk) if (mem_we) mem[mem_wa] <= mem_wd;
   assign rd_data = mem[rd_addr];
endmodule

// File: tb/tb_data_memory_burst.sv
// tb_data_memory_burst: directed self-checking bench for data_memory_burst
module tb_data_memory_burst;
   import data_memory_pkg::*;
   logic clk = 1'b0, reset = 1'b0;
   logic [7:0] rd_addr = '0, wr_addr = '0, base_addr = '0;
   logic [15:0] rd_data, wr_data = '0, reg_rdata, reg_wdata;
   logic wr_en = 1'b0, wr_drop, start = 1'b0, mode = 1'b0, reg_we, busy, done;
   logic [7:0] mask = '0;
   logic [2:0] reg_idx;
   logic [15:0] rf [8];
   int checks = 0, fails = 0;
   always #5 clk = ~clk;
   assign reg_rdata = rf[reg_idx];
   data_memory_burst dut (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(wr_drop),
      .start(start), .mode(mode), .base_addr(base_addr), .mask(mask),
      .reg_idx(reg_idx), .reg_rdata(reg_rdata), .reg_we(reg_we), .reg_wdata(reg_wdata),
      .busy(busy), .done(done)
   );
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset;
      int n;
      wr_en = 1'b1;
      wr_addr = 8'h05;
      wr_data = 16'hBEEF;
      repeat (3) tick();
      checks++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b want 1", busy); end
      checks++; if (done !== 1'b0 || reg_we !== 1'b0) begin fails++; $display("FAIL reset_done_we: got done=%b we=%b want 0/0", done, reg_we); end
      checks++; if (wr_drop !== 1'b0) begin fails++; $display("FAIL reset_wr_drop: got %b want 0", wr_drop); end
      checks++; if (reg_idx !== 3'd0 || reg_wdata !== 16'h0) begin fails++; $display("FAIL reset_idx_wdata: got %0d/%h want 0/0000", reg_idx, reg_wdata); end
      wr_en = 1'b0;
      reset = 1'b1;
      n = 0;
      while (busy && n < 1000) begin
         if (n == 10) begin
            wr_en = 1'b1;
            #1;
            checks++; if (wr_drop !== 1'b1) begin fails++; $display("FAIL init_wr_drop: got %b want 1", wr_drop); end
            wr_en = 1'b0;
         end
         n++;
         tick();
      end
      checks++; if (n != 256) begin fails++; $display("FAIL init_busy_len: got %0d want 256", n); end
      rd_addr = 8'd0; #1;
      checks++; if (rd_data !== 16'h0) begin fails++; $display("FAIL clear_0: got %h want 0000", rd_data); end
      rd_addr = 8'd127; #1;
      checks++; if (rd_data !== 16'h0) begin fails++; $display("FAIL clear_127: got %h want 0000", rd_data); end
      rd_addr = 8'd255; #1;
      checks++; if (rd_data !== 16'h0) begin fails++; $display("FAIL clear_255: got %h want 0000", rd_data); end
      rd_addr = 8'd5; #1;
      checks++; if (rd_data !== 16'h0) begin fails++; $display("FAIL clear_5_after_drop: got %h want 0000", rd_data); end
   endtask
   task automatic test_single;
      wr_en = 1'b1;
      wr_addr = 8'h10;
      wr_data = 16'hA5A5;
      #1;
      checks++; if (wr_drop !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL idle_write_flags: got drop=%b busy=%b want 0/0", wr_drop, busy); end
      tick();
      wr_en = 1'b0;
      rd_addr = 8'h10; #1;
      checks++; if (rd_data !== 16'hA5A5) begin fails++; $display("FAIL single_rd: got %h want a5a5", rd_data); end
   endtask
   task automatic test_sm_burst;
      logic [2:0] exp_idx [3];
      exp_idx = '{3'd1, 3'd4, 3'd7};
      mode = MODE_SM;
      base_addr = 8'h20;
      mask = 8'b1001_0010;
      start = 1'b1;
      tick();
      start = 1'b0;
      mask = '0;
      for (int j = 0; j < 3; j++) begin
         checks++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL sm_busy_%0d: got busy=%b done=%b want 1/0", j, busy, done); end
         checks++; if (reg_idx !== exp_idx[j] || reg_we !== 1'b0) begin fails++; $display("FAIL sm_idx_%0d: got idx=%0d we=%b want %0d/0", j, reg_idx, reg_we, exp_idx[j]); end
         tick();
      end
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL sm_done: got done=%b busy=%b want 1/0", done, busy); end
      tick();
      checks++; if (done !== 1'b0) begin fails++; $display("FAIL sm_done_pulse: got %b want 0", done); end
      rd_addr = 8'h20; #1;
      checks++; if (rd_data !== 16'h1001) begin fails++; $display("FAIL sm_mem20: got %h want 1001", rd_data); end
      rd_addr = 8'h21; #1;
      checks++; if (rd_data !== 16'h1004) begin fails++; $display("FAIL sm_mem21: got %h want 1004", rd_data); end
      rd_addr = 8'h22; #1;
      checks++; if (rd_data !== 16'h1007) begin fails++; $display("FAIL sm_mem22: got %h want 1007", rd_data); end
      rd_addr = 8'h23; #1;
      checks++; if (rd_data !== 16'h0000) begin fails++; $display("FAIL sm_mem23: got %h want 0000", rd_data); end
   endtask
   task automatic test_lm_wrap;
      wr_en = 1'b1;
      wr_addr = 8'hFF;
      wr_data = 16'h1111;
      tick();
      wr_addr = 8'h00;
      wr_data = 16'h2222;
      tick();
      wr_en = 1'b0;
      mode = MODE_LM;
      base_addr = 8'hFF;
      mask = 8'b0000_0101;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (reg_we !== 1'b1 || reg_idx !== 3'd0 || reg_wdata !== 16'h1111) begin fails++; $display("FAIL lm_first: got we=%b idx=%0d data=%h want 1/0/1111", reg_we, reg_idx, reg_wdata); end
      tick();
      checks++; if (reg_we !== 1'b1 || reg_idx !== 3'd2 || reg_wdata !== 16'h2222) begin fails++; $display("FAIL lm_wrap: got we=%b idx=%0d data=%h want 1/2/2222", reg_we, reg_idx, reg_wdata); end
      tick();
      checks++; if (done !== 1'b1 || reg_we !== 1'b0) begin fails++; $display("FAIL lm_done: got done=%b we=%b want 1/0", done, reg_we); end
      tick();
   endtask
   task automatic test_zero_mask;
      mode = MODE_LM;
      mask = '0;
      base_addr = 8'h00;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (done !== 1'b1 || reg_we !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL zero_done: got done=%b we=%b busy=%b want 1/0/0", done, reg_we, busy); end
      tick();
      checks++; if (done !== 1'b0) begin fails++; $display("FAIL zero_done_pulse: got %b want 0", done); end
   endtask
   task automatic test_contention;
      wr_en = 1'b1;
      wr_addr = 8'h40;
      wr_data = 16'h1234;
      tick();
      wr_addr = 8'h60;
      wr_data = 16'h6666;
      mode = MODE_SM;
      base_addr = 8'h50;
      mask = 8'b0000_0011;
      start = 1'b1;
      #1;
      checks++; if (wr_drop !== 1'b0) begin fails++; $display("FAIL start_write_drop: got %b want 0", wr_drop); end
      tick();
      start = 1'b0;
      wr_addr = 8'h40;
      wr_data = 16'hDEAD;
      #1;
      checks++; if (wr_drop !== 1'b1) begin fails++; $display("FAIL burst_drop_0: got %b want 1", wr_drop); end
      tick();
      checks++; if (wr_drop !== 1'b1) begin fails++; $display("FAIL burst_drop_1: got %b want 1", wr_drop); end
      wr_en = 1'b0;
      tick();
      checks++; if (done !== 1'b1) begin fails++; $display("FAIL cont_done: got %b want 1", done); end
      tick();
      rd_addr = 8'h40; #1;
      checks++; if (rd_data !== 16'h1234) begin fails++; $display("FAIL drop_mem: got %h want 1234", rd_data); end
      rd_addr = 8'h60; #1;
      checks++; if (rd_data !== 16'h6666) begin fails++; $display("FAIL start_write_mem: got %h want 6666", rd_data); end
      rd_addr = 8'h50; #1;
      checks++; if (rd_data !== 16'h1000) begin fails++; $display("FAIL cont_mem50: got %h want 1000", rd_data); end
      rd_addr = 8'h51; #1;
      checks++; if (rd_data !== 16'h1001) begin fails++; $display("FAIL cont_mem51: got %h want 1001", rd_data); end
   endtask
   task automatic test_reset_mid;
      int n;
      bit saw_done;
      mode = MODE_SM;
      base_addr = 8'h30;
      mask = 8'b0000_0110;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b1 || done !== 1'b0 || reg_idx !== 3'd0) begin fails++; $display("FAIL mid_reset_out: got busy=%b done=%b idx=%0d want 1/0/0", busy, done, reg_idx); end
      saw_done = 1'b0;
      repeat (2) begin
         tick();
         if (done) saw_done = 1'b1;
      end
      rd_addr = 8'h30; #1;
      checks++; if (rd_data !== 16'h1001) begin fails++; $display("FAIL mid_partial: got %h want 1001", rd_data); end
      rd_addr = 8'h31; #1;
      checks++; if (rd_data !== 16'h0000) begin fails++; $display("FAIL mid_no_second: got %h want 0000", rd_data); end
      reset = 1'b1;
      n = 0;
      while (busy && n < 1000) begin
         if (done) saw_done = 1'b1;
         n++;
         tick();
      end
      checks++; if (n != 256) begin fails++; $display("FAIL mid_init_len: got %0d want 256", n); end
      checks++; if (saw_done !== 1'b0) begin fails++; $display("FAIL mid_no_done: got %b want 0", saw_done); end
      rd_addr = 8'h30; #1;
      checks++; if (rd_data !== 16'h0000) begin fails++; $display("FAIL mid_cleared: got %h want 0000", rd_data); end
   endtask
   initial begin
      for (int i = 0; i < 8; i++) rf[i] = 16'h1000 + 16'(i);
      test_reset();
      test_single();
      test_sm_burst();
      test_lm_wrap();
      test_zero_mask();
      test_contention();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/data_memory_burst.md
Name: data_memory_burst

Overview:
- Parametrised successor to the single-port data memory. Adds a post-reset clear sequencer and a load-multiple/store-multiple (LM/SM) burst engine that moves data between memory and the register file under an N-bit register mask.
- Sits in the MEM stage. The pipeline uses the single-word port for LW/SW and the burst port for LM/SM.
- Memory array is word-addressed. Reads are combinational.

Parameters:
- DATA_W, 16, word width in bits.
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
- NREG, 8, register-mask width; REG_IDX_W = clog2(NREG).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- rd_addr  in  ADDR_W  single-port read address.
- rd_data  out  DATA_W  mem[rd_addr], combinational.
- wr_en  in  1  single-port write enable, active-high.
- wr_addr  in  ADDR_W  single-port write address.
- wr_data  in  DATA_W  single-port write data.
- wr_drop  out  1  pulses when a wr_en was ignored (INIT or burst active).
- start  in  1  burst request, sampled in IDLE only.
- mode  in  1  0 = LM (memory to registers), 1 = SM (registers to memory).
- base_addr  in  ADDR_W  first burst address.
- mask  in  NREG  register select; bit i set selects register i.
- reg_idx  out  REG_IDX_W  register index of the current transfer.
- reg_rdata  in  DATA_W  register-file read data for reg_idx (SM), same cycle.
- reg_we  out  1  register-file write strobe (LM).
- reg_wdata  out  DATA_W  data for reg_we.
- busy  out  1  high in INIT and BURST.
- done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to INIT; init counter = 0.
  - busy=1; done=0, reg_we=0, wr_drop=0, reg_idx=0, reg_wdata=0.
  - Array contents are not touched while reset is asserted.
- INIT:
  - Each cycle writes mem[cnt] = 0 and increments cnt.
  - After the write of DEPTH-1, goes to IDLE; busy falls the following cycle.
  - Total clear takes DEPTH cycles.
  - start and wr_en are ignored; an ignored wr_en raises wr_drop for that cycle.
- IDLE:
  - busy=0. wr_en=1 writes mem[wr_addr] = wr_data at the edge.
  - start=1 latches mode, base_addr and mask; goes to BURST next edge; busy=1 from the next cycle.
  - If start and wr_en are both high in IDLE, the single write is performed in that cycle, then the burst starts.
- BURST:
  - Each cycle the sub-module selects the lowest set bit i of the remaining mask; reg_idx = i.
  - addr = base + k, where k is the number of transfers already done, modulo DEPTH (wraps from DEPTH-1 to 0).
  - LM: reg_we=1, reg_wdata = mem[addr].
  - SM: mem[addr] = reg_rdata at the edge; reg_we=0.
  - Bit i is cleared at the edge. Unset bits cost zero cycles.
  - When the remaining mask is 0, goes to DONE.
  - A mask with m set bits gives exactly m BURST cycles.
  - A zero mask gives zero BURST cycles: IDLE goes straight to DONE.
- DONE:
  - done=1 for one cycle, busy=0 in this cycle, then IDLE.
  - start is not accepted in DONE.
- During BURST, wr_en is dropped with wr_drop=1. rd_data stays live in all states.
- Reset asserted mid-burst aborts the burst with no done pulse. Partial writes already performed remain until the INIT sweep clears them.

Decomposition:
- Package data_memory_pkg holds:
  - FSM state enum {INIT, IDLE, BURST, DONE}.
  - MODE_LM=1'b0 and MODE_SM=1'b1.
  - Default widths.
- Sub-module lmsm_mask_scan: combinational lowest-set-bit priority encoder over NREG bits.
  - Outputs: index, valid, and the mask with that bit cleared.

Test Plan:
- Reset then IDLE: reset low for 3 cycles, then release. Required: busy high for exactly 256 cycles, then rd_data=0x0000 for addresses 0, 127 and 255.
- Single write/read: wr_en, wr_addr=0x10, wr_data=0xA5A5. Required: rd_addr=0x10 returns 0xA5A5 the next cycle.
- SM burst: mode=1, base=0x20, mask=0b10010010, reg_rdata=0x1000+reg_idx.
  - Required: 3 BURST cycles with reg_idx sequence 1, 4, 7.
  - mem[0x20..0x22] = 0x1001, 0x1004, 0x1007.
  - done pulse on cycle 5 after start.
- LM burst with wrap: mem[0xFF]=0x1111, mem[0x00]=0x2222, base=0xFF, mask=0b00000101.
  - Required: reg_we on reg 0 with 0x1111, then on reg 2 with 0x2222.
- Zero mask and contention: start with mask=0 gives done on the 2nd cycle with no reg_we. wr_en during a burst gives wr_drop=1 and memory unchanged.
- Reset mid-burst: reset low during the 2nd SM transfer. Required: busy=1 immediately, no done pulse, and the INIT sweep clears the written word.
